ysyx_24080014_ifu_prefetch: RTL and testbench
=============================================

// Module: ysyx_24080014_ifu_prefetch
// PURPOSE
//  Parametrised instruction-fetch unit with an AXI4-Lite read-master port and a DEPTH-entry prefetch buffer.
//  Fetches sequentially from a PC register and queues {pc, inst, err} entries.
//  Entries go to decode over a valid/ready handshake. A redirect from EXU/WBU flushes the queue and restarts fetch.
//  Sits between the PC/redirect logic and the instruction SRAM/crossbar. Replaces the single-shot fetch path.
// PARAMETERS
//  XLEN      32            address/data width; instruction width is fixed at 32
//  DEPTH     4             prefetch buffer entries; power of 2, >=2
//  RESET_PC  32'h8000_0000 fetch address after reset
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, synchronous, active-low
//  redirect_valid in   1     flush and restart fetch at redirect_pc
//  redirect_pc    in   XLEN  new fetch address; bits[1:0] ignored (forced 0)
//  out_valid      out  1     buffer head valid
//  out_ready      in   1     decode accepts head
//  out_inst       out  32    head instruction
//  out_pc         out  XLEN  head PC
//  out_err        out  1     head fetch returned rresp!=OKAY
//  arvalid        out  1     AXI AR valid
//  arready        in   1     AXI AR ready
//  araddr         out  XLEN  AXI AR address
//  rvalid         in   1     AXI R valid
//  rready         out  1     AXI R ready
//  rdata          in   32    AXI R data
//  rresp          in   2     AXI R response
// BEHAVIOUR
//  Reset (rst==0 at a clk edge):
//   - state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr ptrs=0, drop=0, halt=0.
//   - arvalid=0, rready=0, araddr=RESET_PC, out_valid=0, out_err=0.
//  FSM, one outstanding transaction max:
//   - IDLE: if !halt and (count + 0) < DEPTH, go to AR next cycle with araddr<=fetch_pc and arvalid=1.
//   - AR: hold arvalid and araddr stable until arready. Then arvalid=0, rready=1, go to R.
//   - R: rready=1 until rvalid. Then go to IDLE, rready=0.
//   - A slot is reserved at AR entry, so rready never waits on buffer space.
//  Push on rvalid&rready:
//   - Not dropped: write {araddr, rdata, rresp!=0} at wr_ptr, count++, fetch_pc<=fetch_pc+4 (wraps mod 2^XLEN).
//   - If rresp!=0: set halt. No further AR is issued until a redirect.
//   - drop=1: discard the beat and clear drop. fetch_pc is unchanged.
//  Pop on out_valid&out_ready: rd_ptr++, count--. Same-cycle push+pop leaves count unchanged.
//  Outputs: out_valid=(count!=0), and out_* come from the entry at rd_ptr. The first visible entry appears one cycle after the R handshake.
//  Best-case latency: reset release to arvalid = 1 cycle; R handshake to out_valid = 1 cycle.
//  Throughput: one instruction per 3 cycles with zero-wait slave (IDLE/AR/R).
//  Redirect (redirect_valid=1, takes priority over everything below):
//   - Next cycle: count=0, ptrs=0, out_valid=0, fetch_pc=redirect_pc&~3, halt=0.
//   - A same-cycle pop is ignored. A same-cycle push is discarded.
//   - In AR or R: set drop=1, except in R with rvalid the same cycle, where that beat is discarded directly.
//     arvalid is never withdrawn before arready (AXI rule). The pending response is swallowed, then fetch resumes at the new PC.
//   - A second redirect while drop=1 only updates fetch_pc. drop remains a single flag because at most one transaction is in flight.
//  Full: IDLE stalls while count==DEPTH. A pop in the same cycle does not allow issue until the next cycle.
//  Reset mid-transaction returns to the reset state immediately. The bench slave is reset with the same signal.
// TESTING
//  1. Zero-wait slave returning rdata=araddr^32'hFFFF, out_ready=1
//     -> araddr 0x80000000, 0x80000004, ...; out_pc/out_inst match; out_err=0.
//  2. out_ready=0 -> exactly DEPTH entries fetched, arvalid stays 0.
//     Then a single pop -> exactly one new AR, to RESET_PC+4*DEPTH.
//  3. arready delayed 5 cycles; redirect to 0x80001002 in cycle 2 of AR
//     -> arvalid/araddr stable to handshake, response dropped, next araddr=0x80001000.
//  4. rresp=2'b10 on the 2nd fetch -> 2nd entry has out_err=1 and no further AR.
//     Redirect to 0x80000100 -> fetch resumes there with out_err=0.
//  5. Redirect in the same cycle as pop and rvalid -> next cycle out_valid=0, count=0, beat discarded.
//  6. rst=0 while in R -> next cycle arvalid=0, rready=0, out_valid=0.
//     After release, first araddr=RESET_PC.

Source files
------------

// File: rtl/ysyx_24080014_ifu_prefetch_if.sv
// Bundle between the instruction-fetch unit, the decode/redirect logic and
// the AXI4-Lite read channels of the instruction SRAM or crossbar.
//
// Signals:
//   redirect_valid/redirect_pc : flush the buffer and restart fetch.
//   out_valid/out_ready        : buffer head handed to decode.
//   out_inst/out_pc/out_err    : payload of the buffer head.
//   arvalid/arready/araddr     : AXI4-Lite AR channel.
//   rvalid/rready/rdata/rresp  : AXI4-Lite R channel.
//
// Handshake semantics, shared by out_*, ar* and r*: a transfer happens on a
// rising clk edge where valid and ready are both 1. A source never withdraws
// valid and never changes its payload while valid is high and ready is low.
// Ready may depend on valid.
//
// Modports: master = the fetch unit, slave = everything around it.
interface ysyx_24080014_ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_err;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;

  modport master (
    input  redirect_valid, redirect_pc, out_ready, arready, rvalid, rdata, rresp,
    output out_valid, out_inst, out_pc, out_err, arvalid, araddr, rready
  );

  modport slave (
    output redirect_valid, redirect_pc, out_ready, arready, rvalid, rdata, rresp,
    input  out_valid, out_inst, out_pc, out_err, arvalid, araddr, rready
  );
endinterface

// File: rtl/ysyx_24080014_ifu_prefetch.sv
// Instruction-fetch unit with an AXI4-Lite read master and a DEPTH-entry
// prefetch buffer. Fetches sequentially from fetch_pc, one transaction in
// flight at a time, and queues {pc, inst, err} entries for decode. A redirect
// flushes the buffer and restarts fetch at the new PC. An error response
// halts fetching until the next redirect.
//
// Ports:
//   clk       : clock
//   rst       : synchronous, active-low reset
//   bus       : ysyx_24080014_ifu_prefetch_if.master (redirect, decode, AXI AR/R)
//   dbg_state : current FSM state (0 IDLE, 1 AR, 2 R)
module ysyx_24080014_ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic                                clk,
  input  logic                                rst,
  ysyx_24080014_ifu_prefetch_if.master        bus,
  output logic [1:0]                          dbg_state
);
  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] araddr_q;
  logic            arvalid_q;
  logic            rready_q;
  logic            drop;
  logic            halt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [DEPTH-1:0] err_mem;

  logic r_fire;
  logic push;
  logic pop;

  assign r_fire = rready_q && bus.rvalid;
  // A redirect overrides both queue operations in the same cycle.
  assign push   = r_fire && !drop && !bus.redirect_valid;
  assign pop    = bus.out_valid && bus.out_ready && !bus.redirect_valid;

  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.rready    = rready_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = pc_mem[rd_ptr];
  assign bus.out_inst  = inst_mem[rd_ptr];
  // Gated so a stale or uninitialised slot never shows an error.
  assign bus.out_err   = bus.out_valid && err_mem[rd_ptr];
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      araddr_q  <= RESET_PC;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      drop      <= 1'b0;
      halt      <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      // The bus FSM keeps running through a redirect so an accepted or
      // pending transaction always completes on the AXI side.
      case (state)
        IDLE: begin
          // count is at most DEPTH-1 here, which is the slot reserved for
          // the transaction about to be issued.
          if (!bus.redirect_valid && !halt && count < DEPTH_C) begin
            araddr_q  <= fetch_pc;
            arvalid_q <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state     <= IDLE;
        end
      endcase

      if (bus.redirect_valid) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= bus.redirect_pc & ~XLEN'(3);
        halt     <= 1'b0;
        // The in-flight response belongs to the old stream. If it arrives
        // this very cycle it is simply not written; otherwise remember to
        // swallow it.
        if (state == AR || (state == R && !bus.rvalid)) begin
          drop <= 1'b1;
        end else if (state == R) begin
          drop <= 1'b0;
        end
      end else begin
        if (r_fire && drop) begin
          drop <= 1'b0;
        end
        if (push) begin
          pc_mem[wr_ptr]   <= araddr_q;
          inst_mem[wr_ptr] <= bus.rdata;
          err_mem[wr_ptr]  <= |bus.rresp;
          wr_ptr           <= wr_ptr + PW'(1);
          fetch_pc         <= fetch_pc + XLEN'(4);
          if (|bus.rresp) begin
            halt <= 1'b1;
          end
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24080014_ifu_prefetch.sv
module tb_ysyx_24080014_ifu_prefetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ysyx_24080014_ifu_prefetch_if #(.XLEN(32)) bus ();

  ysyx_24080014_ifu_prefetch #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(RST_PC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- counters and logs ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int ar_delay  = 0;
  int ar_cnt    = 0;
  int err_idx   = -1;
  int fetch_idx = 0;

  logic [31:0] ar_log[$];
  int          ar_cyc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];
  logic        pop_err_q[$];
  logic [31:0] exp_q[$];

  // ---------------- AXI slave model ----------------
  // rdata = araddr ^ 0xFFFF; rresp = SLVERR on fetch number err_idx since reset.
  assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);

  always @(posedge clk) begin
    if (!rst) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= 2'b00;
      ar_cnt     <= 0;
      fetch_idx  <= 0;
    end else if (bus.arvalid && bus.arready) begin
      bus.rvalid <= 1'b1;
      bus.rdata  <= bus.araddr ^ 32'h0000_FFFF;
      bus.rresp  <= (fetch_idx == err_idx) ? 2'b10 : 2'b00;
      fetch_idx  <= fetch_idx + 1;
      ar_cnt     <= 0;
    end else begin
      if (bus.arvalid) ar_cnt <= ar_cnt + 1;
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (bus.arvalid && bus.arready) begin
        ar_log.push_back(bus.araddr);
        ar_cyc_q.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
        pop_pc_q.push_back(bus.out_pc);
        pop_inst_q.push_back(bus.out_inst);
        pop_err_q.push_back(bus.out_err);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    ar_log.delete();
    ar_cyc_q.delete();
    pop_pc_q.delete();
    pop_inst_q.delete();
    pop_err_q.delete();
    exp_q.delete();
  endtask

  // Leaves rst asserted; caller releases it at a negedge.
  task automatic apply_reset();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick(2);
    clear_logs();
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (pop_pc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(pop_pc_q.size()), 64'(n));
  endtask

  task automatic wait_ars(input int n, input int budget, input string tag);
    int k = 0;
    while (ar_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(ar_log.size()), 64'(n));
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    logic [31:0] e;
    int          bad;
    int          k;
    bit          found;

    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // 1. zero-wait sequential fetch
    ar_delay = 0; err_idx = -1; bus.out_ready = 1'b1;
    apply_reset();
    check("rst_arvalid",   bus.arvalid,   1'b0);
    check("rst_rready",    bus.rready,    1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_err",   bus.out_err,   1'b0);
    check("rst_araddr",    bus.araddr,    RST_PC);
    check("rst_state",     dbg_state,     2'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t1_arvalid_lat", bus.arvalid, 1'b1);
    check("t1_araddr0",     bus.araddr,  RST_PC);
    for (int i = 0; i < 4; i++) exp_q.push_back(RST_PC + 32'(4 * i));
    wait_pops(4, 40, "t1_pop_cnt");
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      check($sformatf("t1_pc%0d", i),   pop_pc_q[i],   e);
      check($sformatf("t1_inst%0d", i), pop_inst_q[i], e ^ 32'h0000_FFFF);
      check($sformatf("t1_err%0d", i),  pop_err_q[i],  1'b0);
    end
    check("t1_ar_addr1",   ar_log[1], 32'h8000_0004);
    check("t1_throughput", 64'(ar_cyc_q[1] - ar_cyc_q[0]), 64'd3);

    // 2. full buffer stalls, one pop allows exactly one more fetch
    bus.out_ready = 1'b0;
    apply_reset();
    rst = 1'b1;
    tick(30);
    check("t2_ar_cnt_full", 64'(ar_log.size()), 64'd4);
    check("t2_arvalid_low", bus.arvalid,   1'b0);
    check("t2_out_valid",   bus.out_valid, 1'b1);
    check("t2_head_pc",     bus.out_pc,    RST_PC);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tick(10);
    check("t2_ar_cnt_after", 64'(ar_log.size()), 64'd5);
    check("t2_ar_addr4",     ar_log[4],  32'h8000_0010);
    check("t2_head_pc2",     bus.out_pc, 32'h8000_0004);
    check("t2_arvalid_end",  bus.arvalid, 1'b0);

    // 3. slow arready with a redirect during AR
    ar_delay = 5; bus.out_ready = 1'b1;
    apply_reset();
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!(bus.arvalid === 1'b1 && bus.araddr === RST_PC)) bad++;
      if (c == 1) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_1002;
      end else begin
        bus.redirect_valid = 1'b0;
      end
    end
    check("t3_ar_stable", 64'(bad), 64'd0);
    wait_ars(2, 40, "t3_ar_cnt");
    check("t3_ar_addr1", ar_log[1], 32'h8000_1000);
    wait_pops(1, 40, "t3_pop_cnt");
    check("t3_pop_pc",   pop_pc_q[0],   32'h8000_1000);
    check("t3_pop_inst", pop_inst_q[0], 32'h8000_EFFF);
    ar_delay = 0;

    // 4. error response halts fetch until redirect
    err_idx = 1; bus.out_ready = 1'b1;
    apply_reset();
    rst = 1'b1;
    tick(20);
    check("t4_ar_cnt",  64'(ar_log.size()),   64'd2);
    check("t4_pop_cnt", 64'(pop_pc_q.size()), 64'd2);
    check("t4_err0",    pop_err_q[0], 1'b0);
    check("t4_err1",    pop_err_q[1], 1'b1);
    check("t4_pc1",     pop_pc_q[1],  32'h8000_0004);
    check("t4_halted",  bus.arvalid,  1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_pops(3, 30, "t4_pop_cnt2");
    check("t4_pc2",   pop_pc_q[2],   32'h8000_0100);
    check("t4_err2",  pop_err_q[2],  1'b0);
    check("t4_inst2", pop_inst_q[2], 32'h8000_FEFF);

    // 5. redirect coinciding with pop and rvalid
    err_idx = -1; bus.out_ready = 1'b0;
    apply_reset();
    rst = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 30) begin
      @(negedge clk);
      k++;
      if (bus.rready && bus.rvalid && bus.out_valid) found = 1'b1;
    end
    check("t5_setup", found, 1'b1);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_2000;
    @(negedge clk);
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_no_pop",    64'(pop_pc_q.size()), 64'd0);
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_refill",    bus.out_valid, 1'b1);
    check("t5_head_pc",   bus.out_pc,    32'h8000_2000);
    check("t5_head_inst", bus.out_inst,  32'h8000_DFFF);
    check("t5_ar_addr",   ar_log[ar_log.size() - 1], 32'h8000_2000);

    // 6. reset in the middle of a read
    bus.out_ready = 1'b0;
    apply_reset();
    rst = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 30) begin
      @(negedge clk);
      k++;
      if (bus.rready && bus.out_valid) found = 1'b1;
    end
    check("t6_setup", found, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_arvalid",   bus.arvalid,   1'b0);
    check("t6_rready",    bus.rready,    1'b0);
    check("t6_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    clear_logs();
    rst = 1'b1;
    @(negedge clk);
    check("t6_arvalid_rel", bus.arvalid, 1'b1);
    check("t6_araddr_rel",  bus.araddr,  RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
